// File: rtl/fir_ctrl.sv
// fir_ctrl: loads FIR taps, clears the delay line, streams one frame and flushes the tail with zeros.
module fir_ctrl #(
  parameter int DW = 15,
  parameter int OW = 20,
  parameter int TAPS = 11,
  parameter int LAT = 1,
  parameter int LW = 16,
  localparam int AW = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [LW-1:0] frame_len,
  input  logic          coef_valid,
  output logic          coef_ready,
  input  logic [DW-1:0] coef_data,
  input  logic          s_valid,
  output logic          s_ready,
  input  logic [DW-1:0] s_data,
  output logic          m_valid,
  input  logic          m_ready,
  output logic [OW-1:0] m_data,
  output logic          fir_en,
  output logic          fir_clr,
  output logic [DW-1:0] fir_in,
  output logic          fir_coef_we,
  output logic [AW-1:0] fir_coef_addr,
  output logic [DW-1:0] fir_coef_data,
  input  logic [OW-1:0] fir_out,
  output logic          busy,
  output logic          done
);
  typedef enum logic [2:0] {IDLE, LOAD, CLR, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [AW-1:0] coef_idx_q, coef_idx_d;
  logic [LW:0] in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d, total;
  logic [LAT-1:0] tag_q, tag_d;
  logic zdone_q, zdone_d, adv, hs, coef_hs, tag_in;
  assign total = {1'b0, len_q} + (LW+1)'(TAPS - 1);
  assign m_valid = tag_q[LAT-1];
  assign m_data = fir_out;
  assign adv = !m_valid || m_ready;
  assign hs = m_valid && m_ready;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE || zdone_q;
  assign coef_ready = state_q == LOAD;
  assign coef_hs = coef_ready && coef_valid;
  assign fir_coef_we = coef_hs;
  assign fir_coef_addr = coef_hs ? coef_idx_q : '0;
  assign fir_coef_data = coef_hs ? coef_data : '0;
  assign fir_clr = state_q == CLR;
  assign s_ready = state_q == RUN && adv;
  assign fir_in = state_q == RUN ? s_data : '0;
  assign fir_en = state_q == RUN ? s_valid && adv : state_q == DRAIN && adv;
  // drain feeds beyond the convolution length only push the last real result out
  assign tag_in = state_q == RUN || in_cnt_q < total;
  always_comb begin
    state_d = state_q;
    len_d = len_q;
    coef_idx_d = coef_idx_q;
    in_cnt_d = in_cnt_q + (LW+1)'(fir_en);
    out_cnt_d = out_cnt_q + (LW+1)'(hs);
    tag_d = fir_en ? LAT'({tag_q, tag_in}) : tag_q;
    if (hs && !fir_en) tag_d[LAT-1] = 1'b0;
    zdone_d = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        zdone_d = frame_len == '0;
        if (frame_len != '0) begin
          state_d = LOAD;
          len_d = frame_len;
          coef_idx_d = '0;
          in_cnt_d = '0;
          out_cnt_d = '0;
          tag_d = '0;
        end
      end
      LOAD: if (coef_hs) begin
        coef_idx_d = coef_idx_q + 1'b1;
        if (coef_idx_q == AW'(TAPS - 1)) state_d = CLR;
      end
      CLR: state_d = RUN;
      RUN: if (fir_en && in_cnt_d == {1'b0, len_q}) state_d = DRAIN;
      DRAIN: if (out_cnt_d == total) state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      len_q <= '0;
      coef_idx_q <= '0;
      in_cnt_q <= '0;
      out_cnt_q <= '0;
      tag_q <= '0;
      zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      coef_idx_q <= coef_idx_d;
      in_cnt_q <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      tag_q <= tag_d;
      zdone_q <= zdone_d;
    end
  end
endmodule

// File: tb/tb_fir_ctrl.sv
// tb_fir_ctrl: drives fir_ctrl against a FIR datapath model and checks frames against a full-convolution reference.
module tb_fir_ctrl;
  localparam int DW = 15, OW = 20, TAPS = 11, LAT = 1, LW = 16;
  localparam int AW = $clog2(TAPS);
  logic clk = 0, rst_n = 0, start = 0;
  logic [LW-1:0] frame_len = '0;
  logic coef_valid = 0, coef_ready, s_valid = 0, s_ready, m_valid, m_ready = 1;
  logic [DW-1:0] coef_data = '0, s_data = '0, fir_in, fir_coef_data;
  logic [OW-1:0] m_data, fir_out;
  logic fir_en, fir_clr, fir_coef_we, busy, done;
  logic [AW-1:0] fir_coef_addr;
  int checks = 0, passes = 0;
  int cf[TAPS];
  int xs[$];
  logic [OW-1:0] got[$];
  int ndone, nviol, nload, nclr;
  bit tmo, aborted, post_busy, post_done;
  logic [63:0] rst_outs;
  always #5 clk = ~clk;
  fir_ctrl #(.DW(DW), .OW(OW), .TAPS(TAPS), .LAT(LAT), .LW(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_len(frame_len),
    .coef_valid(coef_valid), .coef_ready(coef_ready), .coef_data(coef_data),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .fir_en(fir_en), .fir_clr(fir_clr), .fir_in(fir_in),
    .fir_coef_we(fir_coef_we), .fir_coef_addr(fir_coef_addr), .fir_coef_data(fir_coef_data),
    .fir_out(fir_out), .busy(busy), .done(done)
  );
  // FIR datapath stand-in: registered output, one result per fir_en edge
  logic signed [DW-1:0] cmem [2**AW];
  logic signed [DW-1:0] hist [TAPS-1];
  logic [OW-1:0] fo;
  assign fir_out = fo;
  function automatic logic [OW-1:0] fir_sum();
    longint a;
    a = longint'(cmem[0]) * longint'($signed(fir_in));
    for (int k = 1; k < TAPS; k++) a += longint'(cmem[k]) * longint'(hist[k-1]);
    return a[OW-1:0];
  endfunction
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fo <= '0;
      for (int i = 0; i < TAPS - 1; i++) hist[i] <= '0;
    end else begin
      if (fir_coef_we) cmem[fir_coef_addr] <= fir_coef_data;
      if (fir_clr) begin
        fo <= '0;
        for (int i = 0; i < TAPS - 1; i++) hist[i] <= '0;
      end else if (fir_en) begin
        fo <= fir_sum();
        hist[0] <= fir_in;
        for (int i = 1; i < TAPS - 1; i++) hist[i] <= hist[i-1];
      end
    end
  end
  function automatic logic [63:0] outs_vec();
    return {2'b0, coef_ready, s_ready, m_valid, m_data, fir_en, fir_clr, fir_coef_we,
            fir_coef_addr, fir_coef_data, fir_in, busy, done};
  endfunction
  function automatic int rnd_s();
    return int'($urandom_range(0, 32767)) - 16384;
  endfunction
  task automatic do_frame(input int len, input int gap, input int bp, input int abort_at, input bit sil);
    int ci, si, cyc;
    bit cacc, sacc, fin;
    ci = 0; si = 0; cyc = 0; fin = 0;
    got.delete();
    ndone = 0; nviol = 0; nload = 0; nclr = 0; aborted = 0; post_busy = 0; post_done = 0;
    @(posedge clk); #1;
    frame_len = LW'(len); start = 1; m_ready = 1;
    coef_valid = 1; coef_data = DW'(cf[0]);
    s_valid = 1; s_data = DW'(xs[0]);
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (m_valid && m_ready) got.push_back(m_data);
      if (fir_en && m_valid && !m_ready) nviol++;
      nload += int'(coef_ready);
      nclr += int'(fir_clr);
      cacc = coef_valid && coef_ready;
      sacc = s_valid && s_ready;
      if (done) begin ndone++; fin = 1; end
      @(posedge clk); #1;
      start = sil && cacc && ci == 3;
      if (start) frame_len = LW'(7);
      ci += int'(cacc);
      si += int'(sacc);
      if (abort_at >= 0 && si == abort_at) begin
        rst_n = 0;
        #1;
        rst_outs = outs_vec();
        aborted = 1;
        fin = 1;
      end
      coef_valid = ci >= TAPS || $urandom_range(99) >= gap;
      coef_data = ci < TAPS ? DW'(cf[ci]) : DW'($urandom);
      s_valid = si >= len || $urandom_range(99) >= gap;
      s_data = si < len ? DW'(xs[si]) : DW'($urandom);
      m_ready = $urandom_range(99) >= bp;
    end
    tmo = !fin;
    if (!aborted) begin
      @(negedge clk);
      post_busy = busy;
      post_done = done;
    end
    @(posedge clk); #1;
    start = 0; coef_valid = 0; s_valid = 0; m_ready = 1;
  endtask
  task automatic test_frame(input string name, input int len, input int gap, input int bp, input bit sil);
    logic [OW-1:0] exp_v[$];
    longint a;
    int bad;
    for (int n = 0; n < len + TAPS - 1; n++) begin
      a = 0;
      for (int k = 0; k < TAPS; k++)
        if (n - k >= 0 && n - k < len) a += longint'(cf[k]) * longint'(xs[n-k]);
      exp_v.push_back(a[OW-1:0]);
    end
    do_frame(len, gap, bp, -1, sil);
    checks++;
    if (tmo) $display("FAIL %s_timeout: frame did not finish within cycle budget", name); else passes++;
    checks++;
    if (got.size() != exp_v.size()) $display("FAIL %s_count: got %0d outputs, expected %0d", name, got.size(), exp_v.size());
    else passes++;
    bad = 0;
    for (int i = 0; i < exp_v.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_v[i]) begin
        if (bad < 20) $display("FAIL %s_data[%0d]: got %h expected %h", name, i, got[i], exp_v[i]);
        bad++;
      end else passes++;
    end
    checks++;
    if (ndone != 1) $display("FAIL %s_done_pulses: got %0d expected 1", name, ndone); else passes++;
    checks++;
    if (post_busy !== 1'b0 || post_done !== 1'b0)
      $display("FAIL %s_after_done: busy=%0b done=%0b expected 0 0", name, post_busy, post_done);
    else passes++;
    checks++;
    if (nviol != 0) $display("FAIL %s_stall: fir_en high during stall %0d times, expected 0", name, nviol); else passes++;
    checks++;
    if (nclr != 1) $display("FAIL %s_clr_cycles: got %0d expected 1", name, nclr); else passes++;
    if (gap == 0) begin
      checks++;
      if (nload != TAPS) $display("FAIL %s_load_cycles: got %0d expected %0d", name, nload, TAPS); else passes++;
    end
  endtask
  task automatic test_reset;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (outs_vec() !== 64'd0) $display("FAIL reset_outputs: got %h expected 0", outs_vec()); else passes++;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    checks++;
    if ({busy, done, m_valid, coef_ready} !== 4'b0)
      $display("FAIL reset_release: busy/done/m_valid/coef_ready=%b expected 0000", {busy, done, m_valid, coef_ready});
    else passes++;
  endtask
  task automatic test_impulse;
    for (int k = 0; k < TAPS; k++) cf[k] = k + 1;
    xs.delete();
    xs.push_back(1);
    for (int i = 1; i < 500; i++) xs.push_back(0);
    test_frame("impulse", 500, 0, 0, 0);
  endtask
  task automatic test_random_stream;
    for (int k = 0; k < TAPS; k++) cf[k] = rnd_s();
    xs.delete();
    for (int i = 0; i < 500; i++) xs.push_back(rnd_s());
    test_frame("stream", 500, 0, 0, 0);
  endtask
  task automatic test_backpressure;
    for (int k = 0; k < TAPS; k++) cf[k] = k + 1;
    xs.delete();
    xs.push_back(1);
    for (int i = 1; i < 500; i++) xs.push_back(0);
    test_frame("backpressure", 500, 30, 50, 0);
  endtask
  task automatic test_zero_len;
    @(posedge clk); #1;
    frame_len = '0; start = 1; coef_valid = 1; s_valid = 1;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) $display("FAIL zero_len_pre: done=%0b expected 0", done); else passes++;
    @(posedge clk); #1;
    start = 0;
    @(negedge clk);
    checks++;
    if ({done, busy, coef_ready} !== 3'b100)
      $display("FAIL zero_len_pulse: done/busy/coef_ready=%b expected 100", {done, busy, coef_ready});
    else passes++;
    @(negedge clk);
    checks++;
    if ({done, busy, coef_ready} !== 3'b000)
      $display("FAIL zero_len_after: done/busy/coef_ready=%b expected 000", {done, busy, coef_ready});
    else passes++;
    coef_valid = 0; s_valid = 0;
  endtask
  task automatic test_back_to_back;
    for (int k = 0; k < TAPS; k++) cf[k] = rnd_s();
    xs.delete();
    xs.push_back(rnd_s());
    test_frame("len1", 1, 0, 0, 0);
    xs.delete();
    for (int i = 0; i < 2; i++) xs.push_back(rnd_s());
    test_frame("len2", 2, 20, 30, 0);
  endtask
  task automatic test_reset_midframe;
    for (int k = 0; k < TAPS; k++) cf[k] = rnd_s();
    xs.delete();
    for (int i = 0; i < 500; i++) xs.push_back(rnd_s());
    do_frame(500, 10, 20, 200, 0);
    checks++;
    if (!aborted) $display("FAIL midreset_reached: aborted=%0b expected 1", aborted); else passes++;
    checks++;
    if (rst_outs !== 64'd0) $display("FAIL midreset_outputs: got %h expected 0", rst_outs); else passes++;
    @(negedge clk) rst_n = 1;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) $display("FAIL midreset_idle: busy=%0b expected 0", busy); else passes++;
    for (int k = 0; k < TAPS; k++) cf[k] = rnd_s();
    xs.delete();
    for (int i = 0; i < 60; i++) xs.push_back(rnd_s());
    test_frame("after_reset", 60, 10, 20, 1);
  endtask
  initial begin
    test_reset;
    test_impulse;
    test_random_stream;
    test_backpressure;
    test_zero_len;
    test_back_to_back;
    test_reset_midframe;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
